// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the multi-cycle controller and the
//               downstream ALU-op decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXE    = 4'd6,
    R_WB     = 4'd7,
    I_EXE    = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_ORI  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // First execution state for an opcode; unknown opcodes land in HALT.
  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE:      nxt = R_EXE;
      OP_LW, OP_SW:  nxt = MEM_ADDR;
      OP_ORI:        nxt = I_EXE;
      OP_BEQ:        nxt = BRANCH;
      OP_J:          nxt = JUMP;
      default:       nxt = HALT;
    endcase
    return nxt;
  endfunction

  function automatic logic is_mem_state(input state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout.sv
// ============================================================================
// Module      : mem_timeout
// Description : Counts consecutive memory wait cycles; flags the cycle on
//               which the TIMEOUT-th wait completes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Expiry is raised during the last allowed wait so the FSM leaves on that edge.
  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// Module      : multi_cycle_ctrl
// Description : Multi-cycle MIPS-subset control unit with memory-wait
//               timeout, illegal-opcode halt and retired-instruction count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUctr,
  output logic [1:0]  PCSource,
  output logic        halt,
  output logic [1:0]  err,
  output logic [31:0] instr_cnt
);

  state_e      state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;
  logic        in_mem, tmo_clear, tmo_en, tmo_expired;

  // The branch decision on zero is taken in the datapath via PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  assign in_mem    = is_mem_state(state_q);
  assign tmo_en    = in_mem && !mem_ready;
  assign tmo_clear = !in_mem || mem_ready;

  mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    retire  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (tmo_expired) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        state_d = decode_next(opcode);
        if (state_d == HALT) err_d = ERR_ILLEGAL;
      end
      MEM_ADDR: begin
        if (opcode == OP_LW) begin
          state_d = MEM_RD;
        end else if (opcode == OP_SW) begin
          state_d = MEM_WR;
        end else begin
          state_d = HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      MEM_RD: begin
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (tmo_expired) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end else if (tmo_expired) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      R_EXE:  state_d = R_WB;
      I_EXE:  state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    instr_cnt_d = retire ? (instr_cnt_q + 32'd1) : instr_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      err_q       <= ERR_NONE;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUctr      = ALU_ADD;
    PCSource    = PCSRC_ALU;
    unique case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE:   ALUSrcB = SRCB_SHIMM;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      R_EXE: begin
        ALUSrcA = 1'b1;
        ALUctr  = ALU_FUNC;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      I_EXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUctr  = ALU_ORI;
      end
      I_WB:     RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUctr      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign halt      = (state_q == HALT);
  assign err       = err_q;
  assign instr_cnt = instr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
// ============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Directed and randomized bench for multi_cycle_ctrl against an
//               instruction-plan reference model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_cycle_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, halt;
  logic [1:0]  ALUSrcB, ALUctr, PCSource, err;
  logic [31:0] instr_cnt;

  multi_cycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctr(ALUctr),
    .PCSource(PCSource), .halt(halt), .err(err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, actr, psrc;
    logic hlt;
    logic [1:0] er;
  } ctl_t;

  // Model: the remaining steps of the current instruction, consumed one per cycle.
  typedef enum int {M_FETCH, M_DEC, M_ADDR, M_RD, M_MWB, M_WR, M_REXE, M_RWB,
                    M_IEXE, M_IWB, M_BR, M_J, M_HALT} ph_t;

  ph_t         plan[$];
  int          waitc;
  logic [31:0] icnt;
  logic [1:0]  merr;
  int          n_vec = 0, n_bad = 0;
  bit          cmp_en = 1'b0;

  function automatic ctl_t expect_ctl(ph_t ph, logic rdy, logic [1:0] er);
    ctl_t c = '0;
    case (ph)
      M_FETCH: begin c.mr = 1; c.asb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      M_DEC:   c.asb = 2'b11;
      M_ADDR:  begin c.asa = 1; c.asb = 2'b10; end
      M_RD:    begin c.mr = 1; c.iord = 1; end
      M_MWB:   begin c.rw = 1; c.m2r = 1; end
      M_WR:    begin c.mw = 1; c.iord = 1; end
      M_REXE:  begin c.asa = 1; c.actr = 2'b10; end
      M_RWB:   begin c.rw = 1; c.rdst = 1; end
      M_IEXE:  begin c.asa = 1; c.asb = 2'b10; c.actr = 2'b11; end
      M_IWB:   c.rw = 1;
      M_BR:    begin c.asa = 1; c.actr = 2'b01; c.pcwc = 1; c.psrc = 2'b01; end
      M_J:     begin c.pcw = 1; c.psrc = 2'b10; end
      M_HALT:  begin c.hlt = 1; c.er = er; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic model_reset();
    plan.delete(); plan.push_back(M_FETCH);
    waitc = 0; icnt = 32'd0; merr = 2'b00;
  endtask

  task automatic model_step();
    ph_t ph = plan[0];
    if (ph == M_HALT) return;
    if ((ph == M_FETCH || ph == M_RD || ph == M_WR) && !mem_ready) begin
      waitc++;
      if (waitc == TO) begin plan.delete(); plan.push_back(M_HALT); merr = 2'b10; end
      return;
    end
    waitc = 0;
    if (ph == M_FETCH) begin plan.delete(); plan.push_back(M_DEC); return; end
    if (ph == M_DEC) begin
      plan.delete();
      case (opcode)
        6'b000000: begin plan.push_back(M_REXE); plan.push_back(M_RWB); end
        6'b100011: begin plan.push_back(M_ADDR); plan.push_back(M_RD); plan.push_back(M_MWB); end
        6'b101011: begin plan.push_back(M_ADDR); plan.push_back(M_WR); end
        6'b001101: begin plan.push_back(M_IEXE); plan.push_back(M_IWB); end
        6'b000100: plan.push_back(M_BR);
        6'b000010: plan.push_back(M_J);
        default:   begin plan.push_back(M_HALT); merr = 2'b01; end
      endcase
      return;
    end
    void'(plan.pop_front());
    if (plan.size() == 0) begin plan.push_back(M_FETCH); icnt = icnt + 32'd1; end
  endtask

  always @(posedge clk) if (rst_n && cmp_en) model_step();

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      ctl_t e, a;
      e = expect_ctl(plan[0], mem_ready, merr);
      a = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUctr, PCSource, halt, err};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL ctl t=%0t phase=%0d rdy=%b got=%b expected=%b", $time, int'(plan[0]), mem_ready, a, e);
      end
      n_vec++;
      if (instr_cnt !== icnt) begin
        n_bad++;
        $display("FAIL instr_cnt t=%0t got=%0d expected=%0d", $time, instr_cnt, icnt);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy);
    opcode = op; mem_ready = rdy; zero = 1'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset(); cmp_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int stall;
    do_reset();
    chk("rst_memread", 32'(MemRead), 32'd1);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_cnt", instr_cnt, 32'd0);

    // R-type: FETCH, DECODE, R_EXE, R_WB
    step(6'h00, 1); step(6'h00, 1); step(6'h00, 1);
    chk("rtype_wb_regwrite", 32'(RegWrite), 32'd1);
    chk("rtype_wb_regdst", 32'(RegDst), 32'd1);
    step(6'h00, 1);
    chk("rtype_cnt", instr_cnt, 32'd1);

    // lw with three wait cycles in MEM_RD: eight cycles total
    step(6'h23, 1); step(6'h23, 1); step(6'h23, 1);
    step(6'h23, 0); step(6'h23, 0); step(6'h23, 0); step(6'h23, 1);
    chk("lw_wb_memtoreg", 32'(MemtoReg), 32'd1);
    chk("lw_cnt_before_retire", instr_cnt, 32'd1);
    step(6'h23, 1);
    chk("lw_cnt", instr_cnt, 32'd2);
    chk("lw_back_fetch", 32'(MemRead & ~IorD), 32'd1);

    // beq
    step(6'h04, 1); step(6'h04, 1);
    chk("beq_aluctr", 32'(ALUctr), 32'd1);
    chk("beq_pcsource", 32'(PCSource), 32'd1);
    chk("beq_pcwritecond", 32'(PCWriteCond), 32'd1);
    step(6'h04, 1);
    chk("beq_cnt", instr_cnt, 32'd3);

    // sw stalled in MEM_WR, then asynchronous reset mid-cycle
    step(6'h2b, 1); step(6'h2b, 1); step(6'h2b, 0);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    #2; rst_n = 1'b0; model_reset();
    #1;
    chk("async_memwrite", 32'(MemWrite), 32'd0);
    chk("async_memread", 32'(MemRead), 32'd1);
    chk("async_cnt", instr_cnt, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Illegal opcode
    step(6'h3f, 1); step(6'h3f, 1);
    chk("illegal_halt", 32'(halt), 32'd1);
    chk("illegal_err", 32'(err), 32'd1);
    repeat (4) step(6'h00, 1);
    chk("illegal_sticky", 32'(halt), 32'd1);
    do_reset();
    chk("illegal_cleared", 32'({halt, err}), 32'd0);

    // Timeout boundary: 14 waits survive, the 15th faults
    repeat (14) step(6'h00, 0);
    chk("tmo14_nohalt", 32'(halt), 32'd0);
    step(6'h00, 0);
    chk("tmo15_halt", 32'(halt), 32'd1);
    chk("tmo15_err", 32'(err), 32'd2);
    do_reset();
    repeat (14) step(6'h00, 0);
    step(6'h00, 1);
    chk("tmo14_decode", 32'(ALUSrcB), 32'd3);
    chk("tmo14_err", 32'(err), 32'd0);

    // Randomized instruction streams
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      stall = 0;
      for (int c = 0; c < 250; c++) begin
        logic [5:0] op;
        logic       rdy;
        int         r;
        op = opcode;
        if (plan[0] == M_FETCH) begin
          r = $urandom_range(0, 19);
          if (r < 3)       op = 6'h00;
          else if (r < 6)  op = 6'h23;
          else if (r < 9)  op = 6'h2b;
          else if (r < 12) op = 6'h0d;
          else if (r < 15) op = 6'h04;
          else if (r < 18) op = 6'h02;
          else             op = 6'($urandom);
        end
        if (stall > 0) begin
          rdy = 1'b0; stall--;
        end else if ($urandom_range(0, 99) < 3) begin
          stall = $urandom_range(8, 16); rdy = 1'b0;
        end else begin
          rdy = ($urandom_range(0, 99) < 80);
        end
        step(op, rdy);
        if (plan[0] == M_HALT && $urandom_range(0, 3) == 0) do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
